// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types for the instruction/data memory arbiter.
//   mem_owner_t : which core port issued a memory read.
//   mem_tag_t   : one response-tracking entry {valid, owner}.
//   TAG_NONE    : empty entry, pushed for idle cycles and writes.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } mem_owner_t;

  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } mem_tag_t;

  localparam mem_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_I};

endpackage

// File: rtl/mem_arbiter_resp_pipe.sv
// -----------------------------------------------------------------------------
// mem_resp_pipe
//   RD_LATENCY-deep shift register of read tags that tracks which port owns
//   each read in flight, so m_rdata can be steered back when it arrives.
// Ports
//   clk, rst   clock, asynchronous active-low reset
//   push       tag entering the pipe this cycle (TAG_NONE if no read)
//   kill       flush fetch reads already in the pipe; suppress i_rvalid now
//   i_rvalid   tail entry is a live fetch read
//   d_rvalid   tail entry is a data-port load
// -----------------------------------------------------------------------------
module mem_resp_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  mem_tag_t push,
  input  logic     kill,
  output logic     i_rvalid,
  output logic     d_rvalid
);

  mem_tag_t stage [RD_LATENCY];
  mem_tag_t tail;

  // NOTE: this small tag array is reset, unlike a data RAM, because a stale
  // valid bit would surface as a spurious rvalid after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RD_LATENCY; k++) stage[k] <= TAG_NONE;
    end else begin
      // NOTE: non-blocking assignments let every stage shift on the old value
      // of its neighbour, independent of statement order.
      // The head entry is this cycle's grant and is never killed.
      stage[0] <= push;
      for (int k = 1; k < RD_LATENCY; k++) begin
        stage[k] <= (kill && stage[k-1].owner == OWN_I) ? TAG_NONE : stage[k-1];
      end
    end
  end

  assign tail     = stage[RD_LATENCY-1];
  assign i_rvalid = tail.valid && (tail.owner == OWN_I) && !kill;
  assign d_rvalid = tail.valid && (tail.owner == OWN_D);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one synchronous single-port SRAM between the core's fetch (i_*)
//   and data (d_*) ports. One combinational grant per cycle, fully pipelined.
//   The data port wins ties unless it has been granted STARVE_MAX times in a
//   row while a fetch was waiting; then the fetch is forced through.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   i_req/i_addr/i_kill      fetch request, address, in-flight fetch flush
//   i_gnt/i_rvalid/i_rdata   fetch grant and read response
//   d_req/d_addr/d_we/d_wdata data request (d_we == 0 is a load)
//   d_gnt/d_rvalid/d_rdata   data grant and load response
//   m_en/m_addr/m_we/m_wdata memory strobe and request fields
//   m_rdata                  memory read data, RD_LATENCY after a read strobe
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int STREAK_W = $clog2(STARVE_MAX + 1);

  logic [STREAK_W-1:0] streak;
  logic                force_i;
  mem_tag_t            push;

  assign force_i = (streak == STREAK_W'(STARVE_MAX));

  // Grants are gated by reset so nothing reaches the memory while rst is low.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (i_req && (!d_req || force_i)) i_gnt = 1'b1;
      else if (d_req)                   d_gnt = 1'b1;
    end
  end

  // Consecutive D grants while a fetch waits; saturates at STARVE_MAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       streak <= '0;
    else if (!i_req || i_gnt)       streak <= '0;
    else if (d_gnt && !force_i)     streak <= streak + 1'b1;
  end

  // Memory mux: idle cycles present the D-port address/data with no write.
  assign m_en    = i_gnt | d_gnt;
  assign m_addr  = i_gnt ? i_addr : d_addr;
  assign m_we    = d_gnt ? d_we : 4'b0000;
  assign m_wdata = d_wdata;

  // Writes complete at grant and never produce a response.
  always_comb begin
    push       = TAG_NONE;
    push.valid = i_gnt || (d_gnt && d_we == 4'b0000);
    push.owner = i_gnt ? OWN_I : OWN_D;
  end

  mem_resp_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_resp_pipe (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .kill     (i_kill),
    .i_rvalid (i_rvalid),
    .d_rvalid (d_rvalid)
  );

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter with a behavioural SRAM, a
//   transaction-level reference model and a response scoreboard.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int SMAX   = 4;
  localparam int WORDS  = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_req = 1'b0, i_kill = 1'b0, d_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
  logic [3:0]        d_we = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              i_gnt, i_rvalid, d_gnt, d_rvalid, m_en;
  logic [DATA_W-1:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_we;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int k);
    return 32'h5A00_0000 ^ (32'(k) * 32'h0001_0203);
  endfunction

  // ---------------- behavioural SRAM (environment, not the reference) -------
  logic [31:0] sram    [WORDS];
  logic [31:0] rd_pipe [LAT];
  logic        s_en;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_we;

  // Sample the strobe mid-cycle so the model never races the DUT's own edge.
  always @(negedge clk) begin
    s_en <= m_en; s_addr <= m_addr; s_we <= m_we; s_wdata <= m_wdata;
  end

  always @(posedge clk) begin
    rd_pipe[0] <= (s_en && s_we == 4'b0) ? sram[s_addr[9:2]] : $urandom;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (s_en)
      for (int b = 0; b < 4; b++)
        if (s_we[b]) sram[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
  end
  assign m_rdata = rd_pipe[LAT-1];

  // ---------------- reference model state ------------------------------------
  typedef struct {
    int          due;
    int          issued;
    logic [31:0] data;
  } resp_t;

  resp_t       iq[$];
  resp_t       dq[$];
  logic [31:0] ref_mem [WORDS];
  bit          i_pend = 0, d_pend = 0;
  logic [31:0] i_pa = '0, d_pa = '0, d_pwd = '0;
  logic [3:0]  d_pwe = '0;
  int          d_run = 0;   // D grants in a row while a fetch was waiting

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: new requests are taken only when the port is not already
  // waiting, so pending requests stay stable until the model says granted.
  task automatic step(input bit wi, input logic [31:0] ia,
                      input bit wd, input logic [31:0] da,
                      input logic [3:0] dwe, input logic [31:0] dwd,
                      input bit kill);
    bit    ei, ed, i_wait;
    resp_t r;
    resp_t keep[$];
    @(posedge clk); #1;
    if (!i_pend && wi) begin i_pend = 1; i_pa = ia; end
    if (!d_pend && wd) begin d_pend = 1; d_pa = da; d_pwe = dwe; d_pwd = dwd; end
    i_req = i_pend; i_addr = i_pa; i_kill = kill;
    d_req = d_pend; d_addr = d_pa; d_we = d_pwe; d_wdata = d_pwd;
    #1;
    i_wait = i_pend;
    ei = i_pend && (!d_pend || d_run >= SMAX);
    ed = d_pend && !ei;
    check("i_gnt", i_gnt, ei);
    check("d_gnt", d_gnt, ed);
    check("m_en", m_en, ei | ed);
    if (ei) begin
      check("m_addr_i", m_addr, i_pa);
      check("m_we_i", m_we, 4'b0);
    end else if (ed) begin
      check("m_addr_d", m_addr, d_pa);
      check("m_we_d", m_we, d_pwe);
      check("m_wdata_d", m_wdata, d_pwd);
    end else begin
      check("m_addr_idle", m_addr, d_pa);
      check("m_we_idle", m_we, 4'b0);
    end
    if (kill) begin
      foreach (iq[k]) if (iq[k].issued >= cyc) keep.push_back(iq[k]);
      iq = keep;
    end
    if (ei) begin
      r.due = cyc + LAT; r.issued = cyc; r.data = ref_mem[i_pa[9:2]];
      iq.push_back(r);
      i_pend = 0;
    end
    if (ed) begin
      if (d_pwe == 4'b0) begin
        r.due = cyc + LAT; r.issued = cyc; r.data = ref_mem[d_pa[9:2]];
        dq.push_back(r);
      end else begin
        for (int b = 0; b < 4; b++)
          if (d_pwe[b]) ref_mem[d_pa[9:2]][8*b +: 8] = d_pwd[8*b +: 8];
      end
      d_pend = 0;
    end
    if (!i_wait || ei) d_run = 0;
    else if (ed)       d_run = (d_run + 1 > SMAX) ? SMAX : d_run + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, '0, 4'b0, '0, 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_drop_i_gnt", i_gnt, 0);
    check("rst_drop_d_gnt", d_gnt, 0);
    check("rst_drop_m_en", m_en, 0);
    check("rst_drop_m_we", m_we, 4'b0);
    check("rst_drop_i_rvalid", i_rvalid, 0);
    check("rst_drop_d_rvalid", d_rvalid, 0);
    iq.delete(); dq.delete(); d_run = 0;
    repeat (n) @(posedge clk);
    #1;
    i_req = 0; d_req = 0; i_kill = 0; rst = 1'b1;
  endtask

  // ---------------- response monitor / scoreboard -----------------------------
  always @(negedge clk) begin
    resp_t r;
    if (!rst) begin
      check("rst_i_gnt", i_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_m_en", m_en, 0);
      check("rst_i_rvalid", i_rvalid, 0);
      check("rst_d_rvalid", d_rvalid, 0);
    end else begin
      if (i_rvalid) begin
        if (iq.size() == 0) check("i_rvalid_unexpected", i_rvalid, 0);
        else begin
          r = iq.pop_front();
          check("i_resp_cycle", cyc, r.due);
          check("i_rdata", i_rdata, r.data);
        end
      end else if (iq.size() > 0 && iq[0].due <= cyc) begin
        check("i_resp_missing", i_rvalid, 1);
        void'(iq.pop_front());
      end
      if (d_rvalid) begin
        if (dq.size() == 0) check("d_rvalid_unexpected", d_rvalid, 0);
        else begin
          r = dq.pop_front();
          check("d_resp_cycle", cyc, r.due);
          check("d_rdata", d_rdata, r.data);
        end
      end else if (dq.size() > 0 && dq[0].due <= cyc) begin
        check("d_resp_missing", d_rvalid, 1);
        void'(dq.pop_front());
      end
    end
  end

  // ---------------- requester rule: hold req and fields until granted --------
  logic        i_hold = 0, d_hold = 0;
  logic [31:0] ih_addr, dh_addr, dh_wdata;
  logic [3:0]  dh_we;

  always @(negedge clk) begin
    if (!rst) begin
      i_hold <= 0;
      d_hold <= 0;
    end else begin
      if (i_hold)
        assert (i_req && i_addr == ih_addr)
          else $error("FAIL requester_rule i port changed before grant");
      if (d_hold)
        assert (d_req && d_addr == dh_addr && d_we == dh_we && d_wdata == dh_wdata)
          else $error("FAIL requester_rule d port changed before grant");
      i_hold <= i_req && !i_gnt; ih_addr <= i_addr;
      d_hold <= d_req && !d_gnt; dh_addr <= d_addr; dh_we <= d_we; dh_wdata <= d_wdata;
    end
  end

  // ---------------- stimulus ---------------------------------------------------
  initial begin
    bit          starve_pat [10];
    bit          wi, wd, kl;
    logic [31:0] ia, da;
    logic [3:0]  we;
    starve_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int k = 0; k < WORDS; k++) begin
      sram[k]    = init_word(k);
      ref_mem[k] = init_word(k);
    end
    for (int k = 0; k < LAT; k++) rd_pipe[k] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Back-to-back fetches.
    step(1, 32'h0, 0, '0, 4'b0, '0, 0);
    step(1, 32'h4, 0, '0, 4'b0, '0, 0);
    step(1, 32'h8, 0, '0, 4'b0, '0, 0);
    idle(LAT + 1);

    // Store wins over a fetch; fetch follows; load the stored word back.
    step(1, 32'h10, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0);
    step(0, '0, 0, '0, 4'b0, '0, 0);
    step(0, '0, 1, 32'h100, 4'b0, '0, 0);
    idle(LAT + 1);

    // Both ports saturated: starvation guard forces every fifth grant to I.
    for (int k = 0; k < 10; k++) begin
      step(1, 32'h200 + 32'(4 * k), 1, 32'h300 + 32'(4 * k), 4'b0, '0, 0);
      check("starve_seq", i_gnt, starve_pat[k]);
    end
    idle(LAT + 1);

    // Kill discards the first fetch but not the one granted in the kill cycle.
    step(1, 32'h30, 0, '0, 4'b0, '0, 0);
    step(1, 32'h20, 0, '0, 4'b0, '0, 1);
    idle(LAT + 2);

    // Load then fetch on consecutive cycles.
    step(0, '0, 1, 32'h40, 4'b0, '0, 0);
    step(1, 32'h44, 0, '0, 4'b0, '0, 0);
    idle(LAT + 1);

    // Reset with two reads in flight; first grant afterwards is clean.
    step(1, 32'h50, 0, '0, 4'b0, '0, 0);
    step(1, 32'h54, 0, '0, 4'b0, '0, 0);
    do_reset(3);
    step(1, 32'h58, 0, '0, 4'b0, '0, 0);
    idle(LAT + 1);

    // Randomized traffic with kills, partial stores and one reset mid-stream.
    for (int n = 0; n < 600; n++) begin
      wi = ($urandom_range(0, 9) < 7);
      wd = ($urandom_range(0, 9) < 6);
      kl = ($urandom_range(0, 9) == 0);
      ia = {22'b0, 6'($urandom_range(0, 63)), 2'b00};
      da = {22'b0, 6'($urandom_range(0, 63)), 2'b00};
      we = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      step(wi, ia, wd, da, we, $urandom, kl);
      if (n == 300) do_reset(2);
    end

    // Let outstanding requests and responses drain.
    for (int n = 0; n < 8; n++) step(0, '0, 0, '0, 4'b0, '0, 0);
    idle(LAT + 2);
    check("i_queue_drained", iq.size(), 0);
    check("d_queue_drained", dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
